// File: rtl/adc_pkg.sv
// rtl/adc_pkg.sv - shared FSM encoding, default constants and timing helpers
// for the burst ADC capture block.
package adc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SHIFT = 2'd2,
    ST_GAP   = 2'd3
  } adc_state_t;

  localparam int DEF_FRAME_BITS = 16;
  localparam int DEF_DATA_BITS  = 12;
  localparam int DEF_CLK_DIV    = 2;
  localparam int DEF_CS_IDLE    = 2;

  // Clock cycles from one conversion start to the next.
  function automatic int conv_period(input int frame_bits, input int clk_div, input int cs_idle);
    return clk_div + 2 * clk_div * frame_bits + cs_idle;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/adc_sclk_gen.sv
// rtl/adc_sclk_gen.sv - divided ADC serial clock with rise/fall ticks.
// sclk is low for CLK_DIV cycles then high for CLK_DIV cycles while en is held.
module adc_sclk_gen
  import adc_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk_20M,
  input  logic reset,
  input  logic en,
  output logic sclk,
  output logic rise,
  output logic fall
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(2 * CLK_DIV) : 1;
  localparam logic [PW-1:0] POS_LAST = PW'(2 * CLK_DIV - 1);
  localparam logic [PW-1:0] POS_RISE = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] POS_HIGH = PW'(CLK_DIV);

  logic          active;
  logic [PW-1:0] pos;
  logic [PW-1:0] pos_next;

  always_comb begin
    pos_next = '0;
    if (active && (pos != POS_LAST)) begin
      pos_next = pos + PW'(1);
    end
  end

  // Ticks mark the edge that ends the current phase, so users act on that same edge.
  assign rise = active && (pos == POS_RISE);
  assign fall = active && (pos == POS_LAST);

  always_ff @(posedge clk_20M) begin
    if (reset || !en) begin
      active <= 1'b0;
      pos    <= '0;
      sclk   <= 1'b1;
    end else begin
      active <= 1'b1;
      pos    <= pos_next;
      sclk   <= (pos_next >= POS_HIGH);
    end
  end

endmodule

// File: rtl/adc_burst_capture.sv
// rtl/adc_burst_capture.sv - burst controller and deserialiser for NUM_CH
// simultaneous-sampling serial ADCs sharing chip-select and sclk.
module adc_burst_capture
  import adc_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int FRAME_BITS = DEF_FRAME_BITS,
  parameter int DATA_BITS  = DEF_DATA_BITS,
  parameter int CLK_DIV    = DEF_CLK_DIV,
  parameter int CS_IDLE    = DEF_CS_IDLE,
  parameter int BURST_LEN  = 128,
  parameter int CNT_W      = 16
) (
  input  logic                        clk_20M,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        stop,
  input  logic [NUM_CH-1:0]           sdata,
  output logic                        adc_sclk,
  output logic                        adc_cs_n,
  output logic [NUM_CH*DATA_BITS-1:0] pdata,
  output logic                        pdata_valid,
  output logic                        busy,
  output logic                        done,
  output logic [CNT_W-1:0]            sample_count,
  output logic                        overrun
);

  localparam int TW = $clog2(max2(CLK_DIV, CS_IDLE) + 1);
  localparam int BW = $clog2(FRAME_BITS + 1);
  localparam int RW = (BURST_LEN > 0) ? $clog2(BURST_LEN + 1) : 1;
  localparam logic [TW-1:0] SETUP_LAST = TW'(CLK_DIV - 1);
  localparam logic [TW-1:0] GAP_LAST   = TW'(CS_IDLE - 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(FRAME_BITS - 1);
  localparam logic [RW-1:0] BURST_INIT = RW'(BURST_LEN);

  adc_state_t state;
  adc_state_t state_next;

  logic [TW-1:0]                  tmr;
  logic [BW-1:0]                  bit_cnt;
  logic [RW-1:0]                  remaining;
  logic                           stop_pend;
  logic [NUM_CH-1:0][FRAME_BITS-1:0] shreg;
  logic                           sclk_rise;
  logic                           sclk_fall;
  logic                           start_ok;
  logic                           frame_end;
  logic                           more_frames;

  assign start_ok    = (state == ST_IDLE) && start && !stop;
  assign frame_end   = (state == ST_SHIFT) && sclk_fall && (bit_cnt == BIT_LAST);
  assign more_frames = !(stop_pend || stop) && ((BURST_LEN == 0) || (remaining != '0));

  adc_sclk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_sclk_gen (
    .clk_20M(clk_20M),
    .reset  (reset),
    .en     (state_next == ST_SHIFT),
    .sclk   (adc_sclk),
    .rise   (sclk_rise),
    .fall   (sclk_fall)
  );

  always_ff @(posedge clk_20M) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:  if (start_ok) state_next = ST_SETUP;
      ST_SETUP: if (tmr == SETUP_LAST) state_next = ST_SHIFT;
      ST_SHIFT: if (frame_end) state_next = ST_GAP;
      ST_GAP:   if (tmr == GAP_LAST) state_next = more_frames ? ST_SETUP : ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_20M) begin
    if (reset) begin
      tmr          <= '0;
      bit_cnt      <= '0;
      remaining    <= '0;
      stop_pend    <= 1'b0;
      shreg        <= '0;
      pdata        <= '0;
      pdata_valid  <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      sample_count <= '0;
      overrun      <= 1'b0;
      adc_cs_n     <= 1'b1;
    end else begin
      // tmr only times SETUP and GAP; SHIFT length comes from sclk fall ticks.
      if ((state_next != state) || (state == ST_IDLE) || (state == ST_SHIFT)) begin
        tmr <= '0;
      end else begin
        tmr <= tmr + TW'(1);
      end

      pdata_valid <= frame_end;
      done        <= (state == ST_GAP) && (state_next == ST_IDLE);
      busy        <= (state_next != ST_IDLE);
      adc_cs_n    <= !((state_next == ST_SETUP) || (state_next == ST_SHIFT));

      if ((state == ST_SHIFT) && sclk_fall) begin
        bit_cnt <= frame_end ? '0 : bit_cnt + BW'(1);
      end

      if ((state != ST_IDLE) && start) begin
        overrun <= 1'b1;
      end

      if (state_next == ST_IDLE) begin
        stop_pend <= 1'b0;
      end else if ((state != ST_IDLE) && stop) begin
        stop_pend <= 1'b1;
      end

      if (start_ok) begin
        sample_count <= '0;
        remaining    <= BURST_INIT;
      end

      if (frame_end) begin
        sample_count <= sample_count + CNT_W'(1);
        remaining    <= remaining - RW'(1);
        for (int i = 0; i < NUM_CH; i++) begin
          pdata[i*DATA_BITS +: DATA_BITS] <= shreg[i][DATA_BITS-1:0];
        end
      end

      if ((state == ST_SHIFT) && sclk_rise) begin
        for (int i = 0; i < NUM_CH; i++) begin
          shreg[i] <= (shreg[i] << 1) | FRAME_BITS'(sdata[i]);
        end
      end
    end
  end

endmodule

// File: tb/tb_adc_burst_capture.sv
// tb/tb_adc_burst_capture.sv - directed self-checking bench for adc_burst_capture
// across single, default-burst, continuous and 4-lane fast-clock configurations.
module tb_adc_burst_capture;

  logic clk_20M = 1'b0;
  always #25 clk_20M = ~clk_20M;

  int n_checks = 0;
  int n_fail   = 0;

  logic rst_a = 1'b1, start_a = 1'b0, stop_a = 1'b0;
  logic rst_b = 1'b1, start_b = 1'b0, stop_b = 1'b0;
  logic rst_c = 1'b1, start_c = 1'b0, stop_c = 1'b0;
  logic rst_d = 1'b1, start_d = 1'b0, stop_d = 1'b0;
  logic [1:0] sdata_a = '0, sdata_b = '0, sdata_c = '0;
  logic [3:0] sdata_d = '0;
  logic sclk_a, cs_a, valid_a, busy_a, done_a, ovr_a;
  logic sclk_b, cs_b, valid_b, busy_b, done_b, ovr_b;
  logic sclk_c, cs_c, valid_c, busy_c, done_c, ovr_c;
  logic sclk_d, cs_d, valid_d, busy_d, done_d, ovr_d;
  logic [23:0] pdata_a, pdata_b, pdata_c;
  logic [63:0] pdata_d;
  logic [15:0] cnt_a, cnt_b, cnt_c, cnt_d;

  adc_burst_capture #(.BURST_LEN(1)) dut_a (
    .clk_20M(clk_20M), .reset(rst_a), .start(start_a), .stop(stop_a), .sdata(sdata_a),
    .adc_sclk(sclk_a), .adc_cs_n(cs_a), .pdata(pdata_a), .pdata_valid(valid_a),
    .busy(busy_a), .done(done_a), .sample_count(cnt_a), .overrun(ovr_a));

  adc_burst_capture dut_b (
    .clk_20M(clk_20M), .reset(rst_b), .start(start_b), .stop(stop_b), .sdata(sdata_b),
    .adc_sclk(sclk_b), .adc_cs_n(cs_b), .pdata(pdata_b), .pdata_valid(valid_b),
    .busy(busy_b), .done(done_b), .sample_count(cnt_b), .overrun(ovr_b));

  adc_burst_capture #(.BURST_LEN(0)) dut_c (
    .clk_20M(clk_20M), .reset(rst_c), .start(start_c), .stop(stop_c), .sdata(sdata_c),
    .adc_sclk(sclk_c), .adc_cs_n(cs_c), .pdata(pdata_c), .pdata_valid(valid_c),
    .busy(busy_c), .done(done_c), .sample_count(cnt_c), .overrun(ovr_c));

  adc_burst_capture #(.NUM_CH(4), .CLK_DIV(1), .DATA_BITS(16), .BURST_LEN(3)) dut_d (
    .clk_20M(clk_20M), .reset(rst_d), .start(start_d), .stop(stop_d), .sdata(sdata_d),
    .adc_sclk(sclk_d), .adc_cs_n(cs_d), .pdata(pdata_d), .pdata_valid(valid_d),
    .busy(busy_d), .done(done_d), .sample_count(cnt_d), .overrun(ovr_d));

  function automatic logic [15:0] word2(input int ch, input int fr);
    return 16'(fr * 291 + ch * 3855 + 33825);
  endfunction

  function automatic logic [15:0] word4(input int ch, input int fr);
    return 16'(fr * 4951 + ch * 9320 + 3855);
  endfunction

  // ADC models: new bit presented on each sclk fall while selected, MSB first.
  int fr_a = 0, idx_a = 0, fr_b = 0, idx_b = 0, fr_c = 0, idx_c = 0, fr_d = 0, idx_d = 0;
  logic [15:0] wa0 = 16'hFABC, wa1 = 16'h0123;
  logic [15:0] wb, wc, wd;

  always @(negedge cs_a) begin idx_a = 0; fr_a++; end
  always @(negedge sclk_a) begin
    if (cs_a === 1'b0 && idx_a < 16) begin
      sdata_a[0] = wa0[15 - idx_a];
      sdata_a[1] = wa1[15 - idx_a];
      idx_a++;
    end
  end

  always @(negedge cs_b) begin idx_b = 0; fr_b++; end
  always @(negedge sclk_b) begin
    if (cs_b === 1'b0 && idx_b < 16) begin
      for (int ch = 0; ch < 2; ch++) begin wb = word2(ch, fr_b - 1); sdata_b[ch] = wb[15 - idx_b]; end
      idx_b++;
    end
  end

  always @(negedge cs_c) begin idx_c = 0; fr_c++; end
  always @(negedge sclk_c) begin
    if (cs_c === 1'b0 && idx_c < 16) begin
      for (int ch = 0; ch < 2; ch++) begin wc = word2(ch, fr_c - 1); sdata_c[ch] = wc[15 - idx_c]; end
      idx_c++;
    end
  end

  always @(negedge cs_d) begin idx_d = 0; fr_d++; end
  always @(negedge sclk_d) begin
    if (cs_d === 1'b0 && idx_d < 16) begin
      for (int ch = 0; ch < 4; ch++) begin wd = word4(ch, fr_d - 1); sdata_d[ch] = wd[15 - idx_d]; end
      idx_d++;
    end
  end

  task automatic step();
    @(posedge clk_20M);
    #1;
  endtask

  task automatic test_reset();
    n_checks++; if (cs_a !== 1'b1) begin n_fail++; $display("FAIL reset_cs_n: got %b want 1", cs_a); end
    n_checks++; if (sclk_a !== 1'b1) begin n_fail++; $display("FAIL reset_sclk: got %b want 1", sclk_a); end
    n_checks++; if (pdata_a !== 24'h0) begin n_fail++; $display("FAIL reset_pdata: got %h want 0", pdata_a); end
    n_checks++; if (valid_a !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid_a); end
    n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy_a); end
    n_checks++; if (done_a !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done_a); end
    n_checks++; if (cnt_a !== 16'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", cnt_a); end
    n_checks++; if (ovr_a !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b want 0", ovr_a); end
  endtask

  task automatic test_single();
    int n = 0;
    int nd = 0;
    start_a = 1'b1; step(); start_a = 1'b0;
    n_checks++; if (busy_a !== 1'b1 || cs_a !== 1'b0) begin n_fail++; $display("FAIL single_accept: busy=%b cs_n=%b want 1/0", busy_a, cs_a); end
    while (valid_a !== 1'b1 && n < 200) begin step(); n++; end
    n_checks++; if (n != 66) begin n_fail++; $display("FAIL single_latency: got %0d want 66", n); end
    n_checks++; if (pdata_a !== 24'h123ABC) begin n_fail++; $display("FAIL single_pdata: got %h want 123abc", pdata_a); end
    n_checks++; if (cnt_a !== 16'd1) begin n_fail++; $display("FAIL single_count: got %0d want 1", cnt_a); end
    n_checks++; if (cs_a !== 1'b1) begin n_fail++; $display("FAIL single_cs_at_valid: got %b want 1", cs_a); end
    while (done_a !== 1'b1 && nd < 20) begin step(); nd++; end
    n_checks++; if (nd != 2) begin n_fail++; $display("FAIL single_done_delay: got %0d want 2", nd); end
    n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL single_busy_at_done: got %b want 0", busy_a); end
    step();
    n_checks++; if (done_a !== 1'b0) begin n_fail++; $display("FAIL single_done_width: got %b want 0", done_a); end
    n_checks++; if (pdata_a !== 24'h123ABC || cnt_a !== 16'd1) begin n_fail++; $display("FAIL single_hold: got %h/%0d want 123abc/1", pdata_a, cnt_a); end
  endtask

  task automatic test_burst();
    int cyc = 0, nvalid = 0, ndone = 0, last = 0, done_cyc = -1;
    int bad_gap = 0, bad_data = 0, bad_cs = 0, n_gaps = 0, cs_hi = 0;
    logic [15:0] w0, w1;
    start_b = 1'b1; step(); start_b = 1'b0;
    while (cyc < 9200 && !(done_cyc >= 0 && cyc >= done_cyc + 20)) begin
      step(); cyc++;
      if (valid_b === 1'b1) begin
        if ((nvalid == 0 && cyc != 66) || (nvalid > 0 && cyc - last != 68)) bad_gap++;
        w0 = word2(0, fr_b - 1); w1 = word2(1, fr_b - 1);
        if (pdata_b !== {w1[11:0], w0[11:0]}) bad_data++;
        nvalid++; last = cyc;
      end
      if (cs_b === 1'b1 && busy_b === 1'b1) cs_hi++;
      else if (cs_b === 1'b0 && cs_hi > 0) begin
        n_gaps++;
        if (cs_hi != 2) bad_cs++;
        cs_hi = 0;
      end
      if (done_b === 1'b1) begin ndone++; if (done_cyc < 0) done_cyc = cyc; end
    end
    n_checks++; if (nvalid != 128) begin n_fail++; $display("FAIL burst_valids: got %0d want 128", nvalid); end
    n_checks++; if (bad_gap != 0) begin n_fail++; $display("FAIL burst_spacing: got %0d bad want 0", bad_gap); end
    n_checks++; if (bad_data != 0) begin n_fail++; $display("FAIL burst_data: got %0d bad want 0", bad_data); end
    n_checks++; if (bad_cs != 0 || n_gaps != 127) begin n_fail++; $display("FAIL burst_cs_gap: got %0d bad of %0d want 0 of 127", bad_cs, n_gaps); end
    n_checks++; if (ndone != 1) begin n_fail++; $display("FAIL burst_done: got %0d want 1", ndone); end
    n_checks++; if (done_cyc - last != 2) begin n_fail++; $display("FAIL burst_done_delay: got %0d want 2", done_cyc - last); end
    n_checks++; if (cnt_b !== 16'd128) begin n_fail++; $display("FAIL burst_count: got %0d want 128", cnt_b); end
    n_checks++; if (busy_b !== 1'b0) begin n_fail++; $display("FAIL burst_busy_end: got %b want 0", busy_b); end
  endtask

  task automatic test_overrun();
    int cyc = 0, nvalid = 0, ndone = 0, done_cyc = -1;
    n_checks++; if (ovr_b !== 1'b0) begin n_fail++; $display("FAIL ovr_initial: got %b want 0", ovr_b); end
    start_b = 1'b1; step(); start_b = 1'b0;
    while (cyc < 9200 && !(done_cyc >= 0 && cyc >= done_cyc + 10)) begin
      step(); cyc++;
      if (valid_b === 1'b1) begin
        nvalid++;
        if (nvalid == 10) begin
          start_b = 1'b1; step(); start_b = 1'b0; cyc++;
          n_checks++; if (ovr_b !== 1'b1) begin n_fail++; $display("FAIL ovr_set: got %b want 1", ovr_b); end
        end
      end
      if (done_b === 1'b1) begin ndone++; if (done_cyc < 0) done_cyc = cyc; end
    end
    n_checks++; if (nvalid != 128 || cnt_b !== 16'd128) begin n_fail++; $display("FAIL ovr_frames: got %0d/%0d want 128/128", nvalid, cnt_b); end
    n_checks++; if (ndone != 1) begin n_fail++; $display("FAIL ovr_done: got %0d want 1", ndone); end
    repeat (50) step();
    n_checks++; if (ovr_b !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky: got %b want 1", ovr_b); end
    rst_b = 1'b1; step(); rst_b = 1'b0;
    n_checks++; if (ovr_b !== 1'b0) begin n_fail++; $display("FAIL ovr_cleared: got %b want 0", ovr_b); end
  endtask

  task automatic test_reset_mid();
    int n = 0, nvalid = 0, late = 0;
    logic [15:0] w0, w1;
    start_b = 1'b1; step(); start_b = 1'b0;
    while (nvalid < 3 && n < 400) begin step(); n++; if (valid_b === 1'b1) nvalid++; end
    n_checks++; if (nvalid != 3) begin n_fail++; $display("FAIL rmid_prefix: got %0d want 3", nvalid); end
    repeat (34) step();
    n_checks++; if (busy_b !== 1'b1 || cs_b !== 1'b0) begin n_fail++; $display("FAIL rmid_in_shift: busy=%b cs_n=%b want 1/0", busy_b, cs_b); end
    rst_b = 1'b1; step();
    n_checks++; if (cs_b !== 1'b1 || sclk_b !== 1'b1) begin n_fail++; $display("FAIL rmid_pins: cs_n=%b sclk=%b want 1/1", cs_b, sclk_b); end
    n_checks++; if (busy_b !== 1'b0 || valid_b !== 1'b0) begin n_fail++; $display("FAIL rmid_flags: busy=%b valid=%b want 0/0", busy_b, valid_b); end
    n_checks++; if (pdata_b !== 24'h0 || cnt_b !== 16'd0) begin n_fail++; $display("FAIL rmid_data: pdata=%h count=%0d want 0/0", pdata_b, cnt_b); end
    rst_b = 1'b0;
    repeat (150) begin step(); if (valid_b !== 1'b0) late++; end
    n_checks++; if (late != 0) begin n_fail++; $display("FAIL rmid_no_valid: got %0d want 0", late); end
    start_b = 1'b1; step(); start_b = 1'b0;
    n = 0;
    while (valid_b !== 1'b1 && n < 200) begin step(); n++; end
    w0 = word2(0, fr_b - 1); w1 = word2(1, fr_b - 1);
    n_checks++; if (n != 66) begin n_fail++; $display("FAIL rmid_restart_latency: got %0d want 66", n); end
    n_checks++; if (pdata_b !== {w1[11:0], w0[11:0]}) begin n_fail++; $display("FAIL rmid_restart_data: got %h want %h", pdata_b, {w1[11:0], w0[11:0]}); end
    rst_b = 1'b1; step(); rst_b = 1'b0;
  endtask

  task automatic test_stop();
    int cyc = 0, nvalid = 0, ndone = 0, stop_at = -1, done_cyc = -1, cs_after = 0, bad_data = 0;
    logic [15:0] w0, w1;
    start_c = 1'b1; stop_c = 1'b1; step(); start_c = 1'b0; stop_c = 1'b0;
    n_checks++; if (busy_c !== 1'b0 || cs_c !== 1'b1) begin n_fail++; $display("FAIL stop_start_together: busy=%b cs_n=%b want 0/1", busy_c, cs_c); end
    stop_c = 1'b1; step(); stop_c = 1'b0;
    start_c = 1'b1; step(); start_c = 1'b0;
    while (cyc < 3000 && !(done_cyc >= 0 && cyc >= done_cyc + 100)) begin
      step(); cyc++;
      stop_c = 1'b0;
      if (valid_c === 1'b1) begin
        w0 = word2(0, fr_c - 1); w1 = word2(1, fr_c - 1);
        if (pdata_c !== {w1[11:0], w0[11:0]}) bad_data++;
        nvalid++;
        if (nvalid == 4) stop_at = cyc + 24;
      end
      if (cyc == stop_at) stop_c = 1'b1;
      if (done_c === 1'b1) begin ndone++; if (done_cyc < 0) done_cyc = cyc; end
      if (done_cyc >= 0 && cyc > done_cyc && cs_c !== 1'b1) cs_after++;
    end
    n_checks++; if (nvalid != 5) begin n_fail++; $display("FAIL stop_valids: got %0d want 5", nvalid); end
    n_checks++; if (cnt_c !== 16'd5) begin n_fail++; $display("FAIL stop_count: got %0d want 5", cnt_c); end
    n_checks++; if (ndone != 1) begin n_fail++; $display("FAIL stop_done: got %0d want 1", ndone); end
    n_checks++; if (cs_after != 0 || busy_c !== 1'b0) begin n_fail++; $display("FAIL stop_no_setup: got %0d low cycles busy=%b want 0/0", cs_after, busy_c); end
    n_checks++; if (bad_data != 0) begin n_fail++; $display("FAIL stop_data: got %0d bad want 0", bad_data); end
  endtask

  task automatic test_variant();
    int cyc = 0, nvalid = 0, ndone = 0, last = 0, done_cyc = -1;
    int bad_gap = 0, bad_data = 0, lows = 0, rises = 0;
    logic prev = 1'b1;
    logic [15:0] w0, w1, w2, w3;
    start_d = 1'b1; step(); start_d = 1'b0;
    while (cyc < 400 && !(done_cyc >= 0 && cyc >= done_cyc + 10)) begin
      step(); cyc++;
      if (nvalid == 0 && cs_d === 1'b0) begin
        if (sclk_d === 1'b0) lows++;
        if (prev === 1'b0 && sclk_d === 1'b1) rises++;
      end
      prev = sclk_d;
      if (valid_d === 1'b1) begin
        if ((nvalid == 0 && cyc != 33) || (nvalid > 0 && cyc - last != 35)) bad_gap++;
        w0 = word4(0, fr_d - 1); w1 = word4(1, fr_d - 1); w2 = word4(2, fr_d - 1); w3 = word4(3, fr_d - 1);
        if (pdata_d !== {w3, w2, w1, w0}) bad_data++;
        nvalid++; last = cyc;
      end
      if (done_d === 1'b1) begin ndone++; if (done_cyc < 0) done_cyc = cyc; end
    end
    n_checks++; if (nvalid != 3 || cnt_d !== 16'd3) begin n_fail++; $display("FAIL var_valids: got %0d/%0d want 3/3", nvalid, cnt_d); end
    n_checks++; if (bad_gap != 0) begin n_fail++; $display("FAIL var_timing: got %0d bad want 0", bad_gap); end
    n_checks++; if (bad_data != 0) begin n_fail++; $display("FAIL var_data: got %0d bad want 0", bad_data); end
    n_checks++; if (lows != 16 || rises != 16) begin n_fail++; $display("FAIL var_sclk: got %0d lows %0d rises want 16/16", lows, rises); end
    n_checks++; if (ndone != 1) begin n_fail++; $display("FAIL var_done: got %0d want 1", ndone); end
  endtask

  initial begin
    repeat (3) step();
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0; rst_d = 1'b0;
    step();
    test_reset();
    test_single();
    test_burst();
    test_overrun();
    test_reset_mid();
    test_stop();
    test_variant();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
